// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared command/character constants, state types and helpers for the LCD time writer
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_SET_ADDR = 8'h80;

    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_DOT   = 8'h2E;
    localparam logic [7:0] CH_DASH  = 8'h2D;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_CLR_WAIT,
        ST_ADDR,
        ST_CHARS,
        ST_GAP
    } main_state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_PULSE,
        PH_HOLD
    } bus_phase_t;

    function automatic logic [7:0] lcd_init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_FUNC_SET;
            2'd1:    return LCD_DISP_ON;
            2'd2:    return LCD_ENTRY;
            default: return LCD_CLEAR;
        endcase
    endfunction

    // Anything the panel cannot print as a plain glyph is shown as '-'.
    function automatic logic [7:0] lcd_sanitise(input logic [7:0] ch);
        return (ch >= 8'h20 && ch <= 8'h7E) ? ch : CH_DASH;
    endfunction

endpackage

// File: rtl/lcd_bus_write.sv
// rtl/lcd_bus_write.sv - one LCD bus write as SETUP/PULSE/HOLD phases, one tick each
module lcd_bus_write
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       nreset,
    input  logic       tick,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    output logic       done
);

    bus_phase_t phase;

    // rs/data are captured on start and held until the next start.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            phase    <= PH_IDLE;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (phase)
                PH_IDLE: begin
                    if (start) begin
                        lcd_rs   <= rs;
                        lcd_data <= data;
                        lcd_e    <= 1'b0;
                        phase    <= PH_SETUP;
                    end
                end
                PH_SETUP: begin
                    if (tick) begin
                        lcd_e <= 1'b1;
                        phase <= PH_PULSE;
                    end
                end
                PH_PULSE: begin
                    if (tick) begin
                        lcd_e <= 1'b0;
                        phase <= PH_HOLD;
                    end
                end
                default: begin
                    if (tick) begin
                        done  <= 1'b1;
                        phase <= PH_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_time_writer.sv
// rtl/lcd_time_writer.sv - initialises an HD44780 LCD and keeps rewriting "HH:MM:SS.cc" on one line
module lcd_time_writer
    import lcd_pkg::*;
#(
    parameter int         TICK_DIV    = 40,
    parameter int         PWRUP_TICKS = 400,
    parameter int         CLR_TICKS   = 50,
    parameter int         GAP_TICKS   = 250,
    parameter logic [6:0] LINE_ADDR   = 7'h00
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [7:0] hour_10,
    input  logic [7:0] hour_1,
    input  logic [7:0] min_10,
    input  logic [7:0] min_1,
    input  logic [7:0] sec_10,
    input  logic [7:0] sec_1,
    input  logic [7:0] cnt_10,
    input  logic [7:0] cnt_1,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       init_done,
    output logic       frame_done
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [3:0]  CHAR_LAST = 4'd10;
    localparam logic [7:0]  ADDR_CMD  = LCD_SET_ADDR | {1'b0, LINE_ADDR};

    logic [15:0]     tick_cnt;
    logic            tick;
    main_state_t     state;
    logic [15:0]     wait_cnt;
    logic [31:0]     wait_lim;
    logic            wait_over;
    logic [1:0]      init_idx;
    logic [3:0]      char_idx;
    logic [3:0]      char_sel;
    logic [7:0]      char_byte;
    logic [7:0][7:0] snap;
    logic            bw_start;
    logic            bw_rs;
    logic [7:0]      bw_data;
    logic            bw_done;

    assign lcd_rw = 1'b0;
    assign tick   = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tick_cnt <= 16'd0;
        end else if (tick) begin
            tick_cnt <= 16'd0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    // A limit of 0 or 1 both finish on the first tick seen in the wait state.
    always_comb begin
        case (state)
            ST_PWRUP:    wait_lim = 32'(PWRUP_TICKS);
            ST_CLR_WAIT: wait_lim = 32'(CLR_TICKS);
            default:     wait_lim = 32'(GAP_TICKS);
        endcase
        wait_over = ({16'd0, wait_cnt} + 32'd1) >= wait_lim;
    end

    // Byte for the character write about to be issued: index 0 when leaving ADDR.
    always_comb begin
        char_sel = (state == ST_CHARS) ? (char_idx + 4'd1) : 4'd0;
        case (char_sel)
            4'd0:    char_byte = lcd_sanitise(snap[0]);
            4'd1:    char_byte = lcd_sanitise(snap[1]);
            4'd2:    char_byte = CH_COLON;
            4'd3:    char_byte = lcd_sanitise(snap[2]);
            4'd4:    char_byte = lcd_sanitise(snap[3]);
            4'd5:    char_byte = CH_COLON;
            4'd6:    char_byte = lcd_sanitise(snap[4]);
            4'd7:    char_byte = lcd_sanitise(snap[5]);
            4'd8:    char_byte = CH_DOT;
            4'd9:    char_byte = lcd_sanitise(snap[6]);
            4'd10:   char_byte = lcd_sanitise(snap[7]);
            default: char_byte = CH_DASH;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= ST_PWRUP;
            wait_cnt   <= 16'd0;
            init_idx   <= 2'd0;
            char_idx   <= 4'd0;
            snap       <= '0;
            bw_start   <= 1'b0;
            bw_rs      <= 1'b0;
            bw_data    <= 8'h00;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            bw_start   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_PWRUP: begin
                    if (tick) begin
                        if (wait_over) begin
                            state    <= ST_INIT;
                            init_idx <= 2'd0;
                            bw_start <= 1'b1;
                            bw_rs    <= 1'b0;
                            bw_data  <= lcd_init_cmd(2'd0);
                        end else begin
                            wait_cnt <= wait_cnt + 16'd1;
                        end
                    end
                end
                ST_INIT: begin
                    if (bw_done) begin
                        if (init_idx == 2'd3) begin
                            state    <= ST_CLR_WAIT;
                            wait_cnt <= 16'd0;
                        end else begin
                            init_idx <= init_idx + 2'd1;
                            bw_start <= 1'b1;
                            bw_rs    <= 1'b0;
                            bw_data  <= lcd_init_cmd(init_idx + 2'd1);
                        end
                    end
                end
                ST_CLR_WAIT, ST_GAP: begin
                    if (tick) begin
                        if (wait_over) begin
                            // Snapshot is taken here so a frame never mixes old and new digits.
                            init_done <= 1'b1;
                            state     <= ST_ADDR;
                            snap      <= {cnt_1, cnt_10, sec_1, sec_10, min_1, min_10, hour_1, hour_10};
                            bw_start  <= 1'b1;
                            bw_rs     <= 1'b0;
                            bw_data   <= ADDR_CMD;
                        end else begin
                            wait_cnt <= wait_cnt + 16'd1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (bw_done) begin
                        state    <= ST_CHARS;
                        char_idx <= 4'd0;
                        bw_start <= 1'b1;
                        bw_rs    <= 1'b1;
                        bw_data  <= char_byte;
                    end
                end
                ST_CHARS: begin
                    if (bw_done) begin
                        if (char_idx == CHAR_LAST) begin
                            frame_done <= 1'b1;
                            state      <= ST_GAP;
                            wait_cnt   <= 16'd0;
                        end else begin
                            char_idx <= char_idx + 4'd1;
                            bw_start <= 1'b1;
                            bw_rs    <= 1'b1;
                            bw_data  <= char_byte;
                        end
                    end
                end
                default: state <= ST_PWRUP;
            endcase
        end
    end

    lcd_bus_write u_bus_write (
        .clk      (clk),
        .nreset   (nreset),
        .tick     (tick),
        .start    (bw_start),
        .rs       (bw_rs),
        .data     (bw_data),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data),
        .done     (bw_done)
    );

endmodule

// File: tb/tb_lcd_time_writer.sv
// tb/tb_lcd_time_writer.sv - scoreboard bench for lcd_time_writer
module tb_lcd_time_writer;

    localparam int TD    = 4;
    localparam int PWRUP = 3;
    localparam int CLR   = 2;
    localparam int GAP   = 2;

    logic       clk;
    logic       nreset;
    logic [7:0] hour_10, hour_1, min_10, min_1, sec_10, sec_1, cnt_10, cnt_1;
    logic       lcd_e, lcd_rs, lcd_rw, init_done, frame_done;
    logic [7:0] lcd_data;

    lcd_time_writer #(
        .TICK_DIV    (TD),
        .PWRUP_TICKS (PWRUP),
        .CLR_TICKS   (CLR),
        .GAP_TICKS   (GAP),
        .LINE_ADDR   (7'h00)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .hour_10    (hour_10),
        .hour_1     (hour_1),
        .min_10     (min_10),
        .min_1      (min_1),
        .sec_10     (sec_10),
        .sec_1      (sec_1),
        .cnt_10     (cnt_10),
        .cnt_1      (cnt_1),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_data   (lcd_data),
        .init_done  (init_done),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] din;
        logic [87:0] dout;
    } vec_t;

    vec_t       vecs [4];
    logic [8:0] exp_q [$];
    int n_checks = 0;
    int n_err    = 0;
    int cyc = 0, rise_cyc = 0, last_fall = 0, fd_cyc = 0, first_rise = -1, wr_count = 0;
    logic prev_e = 1'b0, prev_id = 1'b0, prev_fd = 1'b0, fd_pend = 1'b0;
    logic [8:0] exp_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out", name);
    endtask

    always @(posedge clk) begin
        if (!nreset) cyc = 0;
        else cyc++;
    end

    // Bus monitor: pops the scoreboard on every lcd_e falling edge.
    always @(negedge clk) begin
        if (!nreset) begin
            prev_e = 1'b0; prev_id = 1'b0; prev_fd = 1'b0; fd_pend = 1'b0; first_rise = -1;
        end else begin
            if (lcd_e && !prev_e) begin
                rise_cyc = cyc;
                if (first_rise < 0) first_rise = cyc;
                if (fd_pend) begin
                    check("gap_to_next_addr", cyc, ((fd_cyc / TD) + 1) * TD + GAP * TD);
                    fd_pend = 1'b0;
                end
            end
            if (!lcd_e && prev_e) begin
                check("e_width", cyc - rise_cyc, TD);
                last_fall = cyc;
                wr_count++;
                if (exp_q.size() == 0) begin
                    fail($sformatf("unexpected_write_%0h", {lcd_rs, lcd_data}));
                end else begin
                    exp_w = exp_q.pop_front();
                    check($sformatf("wr%0d_rs_data", wr_count), {lcd_rs, lcd_data}, exp_w);
                end
            end
            if (init_done && !prev_id)
                check("init_done_delay", cyc, last_fall + TD + CLR * TD);
            if (prev_fd) check("frame_done_width", frame_done, 0);
            else if (frame_done) begin
                fd_cyc = cyc;
                fd_pend = 1'b1;
            end
            check("lcd_rw", lcd_rw, 0);
            prev_e  = lcd_e;
            prev_id = init_done;
            prev_fd = frame_done;
        end
    end

    task automatic set_inputs(input logic [63:0] d);
        {hour_10, hour_1, min_10, min_1, sec_10, sec_1, cnt_10, cnt_1} = d;
    endtask

    task automatic push_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
    endtask

    task automatic push_frame(input logic [87:0] d);
        exp_q.push_back(9'h080);
        for (int k = 0; k < 11; k++) exp_q.push_back({1'b1, d[87-8*k -: 8]});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_lcd_e"}, lcd_e, 0);
        check({tag, "_lcd_rs"}, lcd_rs, 0);
        check({tag, "_lcd_rw"}, lcd_rw, 0);
        check({tag, "_lcd_data"}, lcd_data, 0);
        check({tag, "_init_done"}, init_done, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (!init_done && n < 1000) begin @(negedge clk); n++; end
        if (!init_done) fail(tag);
        check({tag, "_first_rise"}, first_rise, (PWRUP + 1) * TD);
    endtask

    task automatic wait_fd(input string tag);
        int n = 0;
        while (!frame_done && n < 1000) begin @(negedge clk); n++; end
        if (!frame_done) fail(tag);
        @(negedge clk);
    endtask

    task automatic wait_pulse_after(input int target, input string tag);
        int n = 0;
        while (wr_count < target && n < 1000) begin @(negedge clk); n++; end
        while (!lcd_e && n < 1100) begin @(negedge clk); n++; end
        if (!lcd_e) fail(tag);
    endtask

    logic [87:0] coh_exp;
    int base;

    initial begin
        vecs[0] = '{din: 64'h31323334_35363738, dout: 88'h31323A_33343A_35362E_3738};
        vecs[1] = '{din: 64'h30393539_35393939, dout: 88'h30393A_35393A_35392E_3939};
        vecs[2] = '{din: 64'h31320034_3536377F, dout: 88'h31323A_2D343A_35362E_372D};
        vecs[3] = '{din: 64'h207E1F80_417AFF5F, dout: 88'h207E3A_2D2D3A_417A2E_2D5F};

        nreset = 1'b1;
        set_inputs(vecs[0].din);
        #3 nreset = 1'b0;
        #1 check_zero("reset");

        push_init();
        push_frame(vecs[0].dout);
        @(negedge clk);
        #1 nreset = 1'b1;
        wait_init("init");
        wait_fd("frame0");

        for (int v = 1; v < 4; v++) begin
            set_inputs(vecs[v].din);
            push_frame(vecs[v].dout);
            wait_fd($sformatf("frame%0d", v));
        end

        // Snapshot coherence: sec_1 changes mid-frame, visible only next frame.
        set_inputs(vecs[0].din);
        push_frame(vecs[0].dout);
        base = wr_count;
        wait_pulse_after(base + 3, "coh_pulse");
        #1 sec_1 = 8'h39;
        wait_fd("coh_frame_a");
        coh_exp = vecs[0].dout;
        coh_exp[87-8*7 -: 8] = 8'h39;
        push_frame(coh_exp);
        wait_fd("coh_frame_b");

        // Reset during PULSE of character index 5.
        push_frame(coh_exp);
        base = wr_count;
        wait_pulse_after(base + 6, "rst_pulse");
        check("pre_reset_lcd_e", lcd_e, 1);
        #1 nreset = 1'b0;
        #1 check_zero("midreset");
        exp_q.delete();
        repeat (3) @(negedge clk);
        push_init();
        push_frame(coh_exp);
        #1 nreset = 1'b1;
        wait_init("reinit");
        wait_fd("reinit_frame");
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_time_writer.md
Name: lcd_time_writer

Overview:
Downstream consumer of the clock/counter stage's eight ASCII digit outputs. It initialises an HD44780-compatible character LCD with a fixed 8-bit write-only sequence. It then repeatedly writes the string "HH:MM:SS.cc" to one LCD line. All bus timing is derived from a single tick divider, so the block needs no busy-flag reads.

Parameters:
TICK_DIV, 40, clk cycles per tick; the tick period must be at least 40 us on the target clock.
PWRUP_TICKS, 400, ticks to wait after reset before the first command.
CLR_TICKS, 50, extra ticks to wait after the clear-display command.
GAP_TICKS, 250, idle ticks between the end of one frame and the start of the next.
LINE_ADDR, 7'h00, DDRAM address of the first character written.

Ports:
clk  in  1  clock
nreset  in  1  asynchronous, active-low reset
hour_10, hour_1, min_10, min_1, sec_10, sec_1, cnt_10, cnt_1  in  8 each  ASCII digits from the counter stage
lcd_e  out  1  LCD enable strobe
lcd_rs  out  1  register select: 0 = command, 1 = data
lcd_rw  out  1  tied to 0 (write only)
lcd_data  out  8  LCD data bus
init_done  out  1  level; goes high once the init sequence completes, stays high until reset
frame_done  out  1  one-clk pulse after the last character of each frame

Behaviour:
- Reset is asynchronous, active-low. All outputs reset to 0: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, init_done=0, frame_done=0. The FSM resets to PWRUP and the tick counter to 0.
- Reset mid-transaction drops lcd_e to 0 immediately, and the full init sequence reruns.
- Tick generation:
  - tick_cnt counts 0..TICK_DIV-1 and wraps.
  - tick is a 1-clk pulse when tick_cnt==TICK_DIV-1.
  - All FSM and bus-phase advances happen only on tick. All outputs are registered.
- Bus write = 3 ticks, one per phase:
  - SETUP: lcd_rs and lcd_data valid, lcd_e=0.
  - PULSE: lcd_e=1.
  - HOLD: lcd_e=0, data held.
  - lcd_rs and lcd_data are stable across all 3 phases. The next write's SETUP follows on the next tick.
- Main FSM states: PWRUP, INIT, CLR_WAIT, ADDR, CHARS, GAP.
  - PWRUP: waits PWRUP_TICKS, then INIT.
  - INIT: issues commands 8'h38, 8'h0C, 8'h06, 8'h01 in order with rs=0. After 8'h01, go to CLR_WAIT.
  - CLR_WAIT: waits CLR_TICKS, then sets init_done=1 and goes to ADDR.
  - ADDR: latches all eight inputs into a snapshot register on the clk cycle of entry. Then writes command {1'b1, LINE_ADDR} with rs=0, then CHARS.
  - CHARS: writes 11 bytes with rs=1, indexed 0..10, in this order: hour_10, hour_1, ':', min_10, min_1, ':', sec_10, sec_1, '.', cnt_10, cnt_1. The digits come from the snapshot.
  - After HOLD of index 10: frame_done pulses for exactly 1 clk, then GAP.
  - GAP: waits GAP_TICKS, then ADDR. This repeats forever.
- Input changes during a frame do not affect that frame; the snapshot guarantees a coherent frame.
- Character sanitising: any snapshot byte outside 8'h20..8'h7E is sent as 8'h2D ('-'). For example, the upstream 8'h00 for an invalid digit is written as '-'.
- Wait counters:
  - Wait counters are 16-bit.
  - A parameter value of 0 means 0 extra ticks: the FSM proceeds on the next tick.
- Index counters:
  - The init index counts 0..3.
  - The character index counts 0..10.
  - Neither wraps mid-sequence; each resets on state entry.

Decomposition:
- Package lcd_pkg holds:
  - command constants LCD_FUNC_SET=8'h38, LCD_DISP_ON=8'h0C, LCD_ENTRY=8'h06, LCD_CLEAR=8'h01, LCD_SET_ADDR=8'h80;
  - character constants CH_COLON=8'h3A, CH_DOT=8'h2E, CH_DASH=8'h2D;
  - the main-state and bus-phase enums.
- One sub-module, lcd_bus_write:
  - inputs: tick, start, rs, data;
  - outputs: lcd_e, lcd_rs, lcd_data, done (1-clk pulse at the end of HOLD).
- The top level holds the tick divider, main FSM, snapshot register and sanitiser.

Test Plan:
All tests use TICK_DIV=4, PWRUP_TICKS=3, CLR_TICKS=2, GAP_TICKS=2.
- Reset check: assert nreset=0 at any time -> all outputs 0 within the same clk, with no clk edge needed.
- Init sequence: release reset -> first lcd_e rise at clk 16 (3 wait ticks plus SETUP tick). Bytes on lcd_e falling edges are 38, 0C, 06, 01, all with rs=0. Each lcd_e pulse is exactly 4 clk wide. init_done rises 2 ticks after the 8'h01 HOLD completes.
- Frame content: inputs "1","2","3","4","5","6","7","8" (hour_10..cnt_1) -> command 80 (rs=0), then 31 32 3A 33 34 3A 35 36 2E 37 38 (rs=1). frame_done is a single-clk pulse after the last HOLD. The next 80 appears after 2 gap ticks.
- Snapshot coherence: change sec_1 from "6" to "9" during CHARS index 2 -> the current frame still shows 36. The next frame shows 39.
- Sanitising: set min_10=8'h00 and cnt_1=8'h7F -> those two positions are written as 2D.
- Reset mid-frame: pulse nreset low during PULSE of CHARS index 5 -> lcd_e drops immediately and init_done goes 0. The sequence restarts from PWRUP with the 38 command.
